// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver FSM states and default line/clock settings
// used by uart_tx, uart_rx and their benches.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        WAIT_HI
    } state_t;

    localparam int DEF_CLK_FREQ   = 100_000_000;
    localparam int DEF_BAUD       = 9600;
    localparam int DEF_OVERSAMPLE = 16;
    localparam int DEF_DATA_BITS  = 8;

endpackage

// File: rtl/uart_rx_if.sv
// Parallel-side bundle of the UART receiver: received byte, strobes, busy flag
// and the FSM state for observation.
interface uart_rx_if #(
    parameter int DATA_BITS = 8
);
    import uart_pkg::*;

    // rx_done is a valid-only strobe with no ready: rx_data is valid in the cycle
    // rx_done is high and holds until the next good frame, so the consumer never stalls us.
    logic [DATA_BITS-1:0] rx_data;
    logic                 rx_done;
    logic                 rx_busy;
    logic                 frame_err;
    state_t               state;

    modport master (
        output rx_data,
        output rx_done,
        output rx_busy,
        output frame_err,
        output state
    );

    modport slave (
        input rx_data,
        input rx_done,
        input rx_busy,
        input frame_err,
        input state
    );

endinterface

// File: rtl/baud_tick_gen.sv
// Oversampling tick generator: one-clk tick every CLK_FREQ/(BAUD*OVERSAMPLE) clocks,
// restartable through clr so the tick phase can follow an external edge.
module baud_tick_gen #(
    parameter int CLK_FREQ   = 100_000_000,
    parameter int BAUD       = 9600,
    parameter int OVERSAMPLE = 16
) (
    input  logic clk,
    input  logic reset,
    input  logic clr,
    output logic tick
);

    localparam int DIV = CLK_FREQ / (BAUD * OVERSAMPLE);
    localparam int CW  = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(DIV - 1);

    logic [CW-1:0] cnt;

    always_ff @(posedge clk) begin
        if (reset || clr) begin
            cnt <= '0;
        end else if (cnt == LAST) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + CW'(1);
        end
    end

    assign tick = (cnt == LAST);

endmodule

// File: rtl/uart_rx.sv
// 8N1-style UART receiver: synchronizes rx, oversamples each bit, takes a 3-sample
// majority vote mid-bit and delivers framed bytes with one-clk done/error strobes.
module uart_rx import uart_pkg::*; #(
    parameter int CLK_FREQ   = DEF_CLK_FREQ,
    parameter int BAUD       = DEF_BAUD,
    parameter int OVERSAMPLE = DEF_OVERSAMPLE,
    parameter int DATA_BITS  = DEF_DATA_BITS
) (
    input  logic      clk,
    input  logic      reset,
    input  logic      rx,
    uart_rx_if.master bus
);

    localparam int M  = OVERSAMPLE / 2;
    localparam int SW = $clog2(OVERSAMPLE);
    localparam int BW = $clog2(DATA_BITS + 1);
    localparam logic [SW-1:0] S_LO   = SW'(M - 1);
    localparam logic [SW-1:0] S_MID  = SW'(M);
    localparam logic [SW-1:0] S_HI   = SW'(M + 1);
    localparam logic [SW-1:0] S_LAST = SW'(OVERSAMPLE - 1);
    localparam logic [BW-1:0] B_LAST = BW'(DATA_BITS - 1);

    state_t               state, next;
    logic                 rx_meta, rx_s;
    logic                 tick, clr, decide, maj;
    logic [SW-1:0]        s;
    logic [BW-1:0]        bcnt;
    logic [1:0]           votes;
    logic [DATA_BITS-1:0] shift, data_q;
    logic                 done_q, err_q;

    // Synchronizer resets to the idle level so reset never looks like a start edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
        end else begin
            rx_meta <= rx;
            rx_s    <= rx_meta;
        end
    end

    assign clr = (state == IDLE) && !rx_s;

    baud_tick_gen #(
        .CLK_FREQ  (CLK_FREQ),
        .BAUD      (BAUD),
        .OVERSAMPLE(OVERSAMPLE)
    ) u_tick (
        .clk  (clk),
        .reset(reset),
        .clr  (clr),
        .tick (tick)
    );

    assign decide = tick && (s == S_HI) &&
                    ((state == START) || (state == DATA) || (state == STOP));
    assign maj    = (votes[0] & votes[1]) | (votes[0] & rx_s) | (votes[1] & rx_s);

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= next;
        end
    end

    always_comb begin
        next = state;
        unique case (state)
            IDLE:    if (!rx_s) next = START;
            START:   if (decide) next = maj ? IDLE : DATA;
            DATA:    if (decide && (bcnt == B_LAST)) next = STOP;
            STOP:    if (decide) next = maj ? IDLE : WAIT_HI;
            WAIT_HI: if (rx_s) next = IDLE;
            default: next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            s      <= '0;
            bcnt   <= '0;
            votes  <= '0;
            shift  <= '0;
            data_q <= '0;
            done_q <= 1'b0;
            err_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            err_q  <= 1'b0;
            if (state == IDLE) begin
                s    <= '0;
                bcnt <= '0;
            end else if (tick) begin
                s <= (s == S_LAST) ? '0 : s + SW'(1);
                if (s == S_LO)  votes[0] <= rx_s;
                if (s == S_MID) votes[1] <= rx_s;
            end
            if (decide) begin
                case (state)
                    DATA: begin
                        shift <= {maj, shift[DATA_BITS-1:1]};
                        bcnt  <= bcnt + BW'(1);
                    end
                    STOP: begin
                        if (maj) begin
                            data_q <= shift;
                            done_q <= 1'b1;
                        end else begin
                            err_q <= 1'b1;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    assign bus.rx_data   = data_q;
    assign bus.rx_done   = done_q;
    assign bus.frame_err = err_q;
    assign bus.rx_busy   = (state != IDLE);
    assign bus.state     = state;

endmodule

// File: tb/tb_uart_rx.sv
// Bench for uart_rx: drives serial frames (directed cases plus random bytes, skew and
// stop-bit errors) and scores every rx_done/frame_err strobe against expected frames.
module tb_uart_rx;

    // Baud picked so the oversampling divider is exact and a frame is ~1.3k clocks.
    localparam int CLK_FREQ   = 100_000_000;
    localparam int BAUD       = 781_250;
    localparam int OVERSAMPLE = 16;
    localparam int BIT_CLKS   = CLK_FREQ / BAUD;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    logic rx    = 1'b1;

    uart_rx_if #(.DATA_BITS(8)) bus ();

    uart_rx #(
        .CLK_FREQ  (CLK_FREQ),
        .BAUD      (BAUD),
        .OVERSAMPLE(OVERSAMPLE),
        .DATA_BITS (8)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .rx   (rx),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    int         vectors     = 0;
    int         miscompares = 0;
    logic [7:0] model_last  = 8'h00;
    logic [8:0] exp_q[$];
    logic [8:0] mon_exp;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Expected entry per frame: {is_error, rx_data seen with the strobe}.
    always @(negedge clk) begin
        if (!reset && (bus.rx_done || bus.frame_err)) begin
            check("done_err_exclusive", 32'(bus.rx_done & bus.frame_err), 32'd0);
            check("event_pending", exp_q.size(), 32'd1);
            if (exp_q.size() > 0) begin
                mon_exp = exp_q.pop_front();
                check(bus.frame_err ? "frame_err_event" : "rx_done_event",
                      32'({bus.frame_err, bus.rx_data}), 32'(mon_exp));
            end
        end
    end

    task automatic idle_bits(input int n);
        #1 rx = 1'b1;
        repeat (n * BIT_CLKS) @(posedge clk);
    endtask

    // reset_bit >= 0 pulses reset mid-way through that bit slot (0 = start bit).
    task automatic send_frame(input logic [7:0] data, input bit stop_ok,
                              input int bit_clks, input int reset_bit);
        logic [9:0] bits;
        bits = {stop_ok, data, 1'b0};
        if (reset_bit < 0) begin
            if (stop_ok) begin
                exp_q.push_back({1'b0, data});
                model_last = data;
            end else begin
                exp_q.push_back({1'b1, model_last});
            end
        end
        for (int b = 0; b < 10; b++) begin
            #1 rx = bits[b];
            if (b == reset_bit) begin
                repeat (bit_clks / 2) @(posedge clk);
                #1 reset = 1'b1;
                @(posedge clk);
                #1 reset = 1'b0;
                model_last = 8'h00;
                check("midrst_rx_data", 32'(bus.rx_data), 32'd0);
                check("midrst_rx_done", 32'(bus.rx_done), 32'd0);
                check("midrst_rx_busy", 32'(bus.rx_busy), 32'd0);
                check("midrst_frame_err", 32'(bus.frame_err), 32'd0);
                repeat (bit_clks - bit_clks / 2 - 1) @(posedge clk);
            end else if (b == 9 && !stop_ok) begin
                repeat (2 * bit_clks) @(posedge clk);
            end else begin
                repeat (bit_clks) @(posedge clk);
            end
        end
        #1 rx = 1'b1;
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1;
        rx    = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("reset_rx_data", 32'(bus.rx_data), 32'd0);
        check("reset_rx_done", 32'(bus.rx_done), 32'd0);
        check("reset_rx_busy", 32'(bus.rx_busy), 32'd0);
        check("reset_frame_err", 32'(bus.frame_err), 32'd0);
        reset = 1'b0;
        idle_bits(2);

        // Clean frame.
        send_frame(8'h55, 1'b1, BIT_CLKS, -1);
        idle_bits(1);
        check("t1_rx_data", 32'(bus.rx_data), 32'(model_last));

        // Short low glitch: a quarter bit, aborted in START.
        #1 rx = 1'b0;
        repeat (BIT_CLKS / 8) @(posedge clk);
        check("t2_busy_on_glitch", 32'(bus.rx_busy), 32'd1);
        repeat (BIT_CLKS / 8) @(posedge clk);
        #1 rx = 1'b1;
        repeat (BIT_CLKS) @(posedge clk);
        check("t2_busy_dropped", 32'(bus.rx_busy), 32'd0);
        check("t2_rx_data_held", 32'(bus.rx_data), 32'(model_last));

        // Bad stop bit, line low for two bit times.
        send_frame(8'hA5, 1'b0, BIT_CLKS, -1);
        idle_bits(1);
        check("t3_rx_data_held", 32'(bus.rx_data), 32'h55);
        check("t3_back_idle", 32'(bus.rx_busy), 32'd0);

        // Back-to-back frames with no idle gap.
        send_frame(8'hA5, 1'b1, BIT_CLKS, -1);
        send_frame(8'h3C, 1'b1, BIT_CLKS, -1);
        idle_bits(1);
        check("t4_rx_data", 32'(bus.rx_data), 32'h3C);

        // Reset during data bit 4, then a clean frame.
        send_frame(8'hFF, 1'b1, BIT_CLKS, 5);
        idle_bits(1);
        check("t5_after_abort", 32'(bus.rx_data), 32'd0);
        send_frame(8'h12, 1'b1, BIT_CLKS, -1);
        idle_bits(1);
        check("t5_rx_data", 32'(bus.rx_data), 32'h12);

        // Transmitter 3% slow.
        send_frame(8'h81, 1'b1, (BIT_CLKS * 103 + 50) / 100, -1);
        idle_bits(1);
        check("t6_rx_data", 32'(bus.rx_data), 32'h81);

        // Random bytes, +-2% skew, occasional bad stop bit, random gaps.
        for (int i = 0; i < 16; i++) begin
            logic [7:0] d;
            bit         ok;
            int         clks;
            int         gap;
            d    = 8'($urandom_range(0, 255));
            ok   = ($urandom_range(0, 4) != 0);
            clks = (BIT_CLKS * $urandom_range(98, 102) + 50) / 100;
            gap  = $urandom_range(0, 2);
            if (!ok && gap == 0) gap = 1;
            send_frame(d, ok, clks, -1);
            if (gap > 0) idle_bits(gap);
        end
        idle_bits(1);
        check("rand_rx_data", 32'(bus.rx_data), 32'(model_last));

        for (int i = 0; i < 4 * BIT_CLKS && exp_q.size() != 0; i++) @(posedge clk);
        check("queue_drained", exp_q.size(), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
